id_decode_pipe: RTL and testbench

ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

---
 rtl/id_decode_pipe_if.sv | 46 ++++
 rtl/id_decode_pipe.sv | 172 +++++++++++++++++
 tb/tb_id_decode_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_decode_pipe_if.sv
// rtl/id_decode_pipe_if.sv - IF/ID, writeback, hazard, debug and ID/EX signal bundle for id_decode_pipe
interface id_decode_pipe_if #(
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_REG  = 5,
  parameter int NB_INST = 32
);
  logic               i_enable;
  logic               i_valid;
  logic [NB_INST-1:0] i_inst;
  logic [NB_PC-1:0]   i_pc;
  logic               i_wb_reg_write;
  logic [NB_REG-1:0]  i_wb_write_reg;
  logic [NB_DATA-1:0] i_wb_write_data;
  logic               i_ex_mem_read;
  logic [NB_REG-1:0]  i_ex_rt;
  logic [NB_REG-1:0]  i_dbg_read_addr;
  logic [NB_DATA-1:0] o_dbg_read_data;
  logic               o_stall;
  logic               o_ex_valid;
  logic [6:0]         o_ex_ctrl;
  logic [NB_DATA-1:0] o_ex_data_a;
  logic [NB_DATA-1:0] o_ex_data_b;
  logic [NB_DATA-1:0] o_ex_imm;
  logic [NB_PC-1:0]   o_ex_pc;
  logic [NB_REG-1:0]  o_ex_rs;
  logic [NB_REG-1:0]  o_ex_rt;
  logic [NB_REG-1:0]  o_ex_rd;
  logic               o_flush;
  logic [NB_PC-1:0]   o_branch_target;
  logic               o_halted;

  modport master (
    output i_enable, i_valid, i_inst, i_pc, i_wb_reg_write, i_wb_write_reg, i_wb_write_data,
           i_ex_mem_read, i_ex_rt, i_dbg_read_addr,
    input  o_dbg_read_data, o_stall, o_ex_valid, o_ex_ctrl, o_ex_data_a, o_ex_data_b, o_ex_imm,
           o_ex_pc, o_ex_rs, o_ex_rt, o_ex_rd, o_flush, o_branch_target, o_halted
  );

  modport slave (
    input  i_enable, i_valid, i_inst, i_pc, i_wb_reg_write, i_wb_write_reg, i_wb_write_data,
           i_ex_mem_read, i_ex_rt, i_dbg_read_addr,
    output o_dbg_read_data, o_stall, o_ex_valid, o_ex_ctrl, o_ex_data_a, o_ex_data_b, o_ex_imm,
           o_ex_pc, o_ex_rs, o_ex_rt, o_ex_rd, o_flush, o_branch_target, o_halted
  );
endinterface

// File: rtl/id_decode_pipe.sv
// rtl/id_decode_pipe.sv - MIPS-style ID stage: decode, write-first regfile, load-use stall, HALT, ID/EX register
// Optional in-ID branch resolution is enabled by defining ID_BRANCH_RESOLVE_EN.
module id_decode_pipe #(
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_REG  = 5,
  parameter int NB_INST = 32
) (
  input logic            i_clock,
  input logic            i_reset,
  id_decode_pipe_if.slave bus
);
  localparam int DEPTH = 2 ** NB_REG;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_HALT} state_t;

  state_t state, state_next;

  logic [NB_DATA-1:0] regs [DEPTH];
  logic [5:0]         opcode;
  logic [NB_REG-1:0]  rs, rt, rd;
  logic [15:0]        imm16;
  logic [NB_DATA-1:0] imm_ext, data_a, data_b;
  logic [NB_PC-1:0]   imm_pc;
  logic [6:0]         ctrl_dec, ctrl_issue;
  logic               wb_en, hazard, stall, issue, flush;
  logic [NB_PC-1:0]   branch_target;

  logic               ex_valid;
  logic [6:0]         ex_ctrl;
  logic [NB_DATA-1:0] ex_data_a, ex_data_b, ex_imm;
  logic [NB_PC-1:0]   ex_pc;
  logic [NB_REG-1:0]  ex_rs, ex_rt, ex_rd;

  assign opcode  = bus.i_inst[31:26];
  assign rs      = NB_REG'(bus.i_inst[25:21]);
  assign rt      = NB_REG'(bus.i_inst[20:16]);
  assign rd      = NB_REG'(bus.i_inst[15:11]);
  assign imm16   = bus.i_inst[15:0];
  assign imm_ext = {{(NB_DATA-16){imm16[15]}}, imm16};
  assign imm_pc  = {{(NB_PC-16){imm16[15]}}, imm16};

  // A frozen pipeline must not see the pending writeback, so the bypass is gated like the write.
  assign wb_en = bus.i_enable && bus.i_wb_reg_write && (bus.i_wb_write_reg != '0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[bus.i_wb_write_reg] <= bus.i_wb_write_data;
    end
  end

  assign data_a = (rs == '0) ? '0 :
                  (wb_en && bus.i_wb_write_reg == rs) ? bus.i_wb_write_data : regs[rs];
  assign data_b = (rt == '0) ? '0 :
                  (wb_en && bus.i_wb_write_reg == rt) ? bus.i_wb_write_data : regs[rt];
  assign bus.o_dbg_read_data =
      (bus.i_dbg_read_addr == '0) ? '0 :
      (wb_en && bus.i_wb_write_reg == bus.i_dbg_read_addr) ? bus.i_wb_write_data :
      regs[bus.i_dbg_read_addr];

  always_comb begin
    ctrl_dec = '0;
    case (opcode)
      OP_RTYPE: ctrl_dec = 7'b1000110;
      OP_LW:    ctrl_dec = 7'b0110110;
      OP_SW:    ctrl_dec = 7'b0101000;
      OP_ADDI:  ctrl_dec = 7'b0100100;
      OP_BEQ:   ctrl_dec = 7'b0000001;
      OP_BNE:   ctrl_dec = 7'b0000001;
      default:  ctrl_dec = '0;
    endcase
  end

  assign hazard = bus.i_valid && bus.i_ex_mem_read && (bus.i_ex_rt != '0) &&
                  ((bus.i_ex_rt == rs) || (bus.i_ex_rt == rt));

  always_ff @(posedge i_clock) begin
    if (i_reset)            state <= ST_RUN;
    else if (bus.i_enable)  state <= state_next;
  end

  // The instruction held during STALL is the one that caused it; EX now carries the bubble.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    issue      = 1'b0;
    if (bus.i_enable) begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            stall      = 1'b1;
            state_next = ST_STALL;
          end else if (bus.i_valid && opcode == OP_HALT) begin
            state_next = ST_HALT;
          end else begin
            issue = bus.i_valid;
          end
        end
        ST_STALL: begin
          state_next = ST_RUN;
          issue      = bus.i_valid && (opcode != OP_HALT);
        end
        ST_HALT: stall = 1'b1;
        default: state_next = ST_RUN;
      endcase
    end
  end

`ifdef ID_BRANCH_RESOLVE_EN
  logic is_branch, taken;
  assign is_branch     = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign taken         = issue && (((opcode == OP_BEQ) && (data_a == data_b)) ||
                                   ((opcode == OP_BNE) && (data_a != data_b)));
  assign flush         = taken;
  assign branch_target = bus.i_pc + imm_pc;
  assign ctrl_issue    = {ctrl_dec[6:1], ctrl_dec[0] & ~is_branch};
`else
  assign flush         = 1'b0;
  assign branch_target = '0;
  assign ctrl_issue    = ctrl_dec;
  logic unused_imm_pc;
  assign unused_imm_pc = ^imm_pc;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_data_a <= '0;
      ex_data_b <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
    end else if (bus.i_enable) begin
      ex_valid  <= issue;
      ex_ctrl   <= issue ? ctrl_issue : '0;
      ex_data_a <= data_a;
      ex_data_b <= data_b;
      ex_imm    <= imm_ext;
      ex_pc     <= bus.i_pc;
      ex_rs     <= rs;
      ex_rt     <= rt;
      ex_rd     <= rd;
    end
  end

  assign bus.o_stall         = stall;
  assign bus.o_flush         = flush;
  assign bus.o_branch_target = branch_target;
  assign bus.o_halted        = (state == ST_HALT);
  assign bus.o_ex_valid      = ex_valid;
  assign bus.o_ex_ctrl       = ex_ctrl;
  assign bus.o_ex_data_a     = ex_data_a;
  assign bus.o_ex_data_b     = ex_data_b;
  assign bus.o_ex_imm        = ex_imm;
  assign bus.o_ex_pc         = ex_pc;
  assign bus.o_ex_rs         = ex_rs;
  assign bus.o_ex_rt         = ex_rt;
  assign bus.o_ex_rd         = ex_rd;
endmodule

// File: tb/tb_id_decode_pipe.sv
// tb/tb_id_decode_pipe.sv - directed plus randomized bench for id_decode_pipe against a behavioural model
module tb_id_decode_pipe;
`ifdef ID_BRANCH_RESOLVE_EN
  localparam bit RESOLVE = 1'b1;
`else
  localparam bit RESOLVE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  id_decode_pipe_if #(.NB_DATA(32), .NB_PC(32), .NB_REG(5), .NB_INST(32)) bus ();

  id_decode_pipe #(.NB_DATA(32), .NB_PC(32), .NB_REG(5), .NB_INST(32)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  bit          m_halted, m_stalled;
  logic        e_valid;
  logic [6:0]  e_ctrl;
  logic [31:0] e_a, e_b, e_imm, e_pc;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic        obs_stall, obs_flush;
  logic [31:0] obs_tgt, obs_dbg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.i_enable && bus.i_wb_reg_write && bus.i_wb_write_reg == a) return bus.i_wb_write_data;
    return m_regs[a];
  endfunction

  function automatic logic [6:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 7'b1000110;
      6'h23:   return 7'b0110110;
      6'h2b:   return 7'b0101000;
      6'h08:   return 7'b0100100;
      6'h04:   return 7'b0000001;
      6'h05:   return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic idle();
    rst = 1'b0;
    bus.i_enable = 1'b1;  bus.i_valid = 1'b0;  bus.i_inst = '0;  bus.i_pc = '0;
    bus.i_wb_reg_write = 1'b0;  bus.i_wb_write_reg = '0;  bus.i_wb_write_data = '0;
    bus.i_ex_mem_read = 1'b0;  bus.i_ex_rt = '0;  bus.i_dbg_read_addr = '0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.i_wb_reg_write = 1'b1;  bus.i_wb_write_reg = r;  bus.i_wb_write_data = d;
  endtask

  // One clock: check combinational outputs at the falling edge, registered ones just after the rising edge.
  task automatic step();
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] ra, rb, sext, e_tgt, e_dbg;
    logic        hz, iss, br, tk, e_stall, e_flush, all_fields;
    logic [6:0]  ctl;
    op = bus.i_inst[31:26];  rs = bus.i_inst[25:21];  rt = bus.i_inst[20:16];  rd = bus.i_inst[15:11];
    sext = {{16{bus.i_inst[15]}}, bus.i_inst[15:0]};
    ra = m_read(rs);  rb = m_read(rt);  e_dbg = m_read(bus.i_dbg_read_addr);
    hz = bus.i_valid && bus.i_ex_mem_read && bus.i_ex_rt != 0 && (bus.i_ex_rt == rs || bus.i_ex_rt == rt);
    e_stall = bus.i_enable && (m_halted || (!m_stalled && hz));
    iss = bus.i_enable && !m_halted && bus.i_valid && op != 6'h3f && !(hz && !m_stalled);
    ctl = ctrl_of(op);
    br  = (op == 6'h04) || (op == 6'h05);
    tk  = iss && br && ((op == 6'h04) == (ra == rb));
    e_flush = RESOLVE ? tk : 1'b0;
    e_tgt   = bus.i_pc + sext;
    if (RESOLVE && br) ctl[0] = 1'b0;

    @(negedge clk);
    obs_stall = bus.o_stall;  obs_flush = bus.o_flush;  obs_tgt = bus.o_branch_target;  obs_dbg = bus.o_dbg_read_data;
    check("stall", obs_stall, e_stall);
    check("flush", obs_flush, e_flush);
    if (e_flush) check("branch_target", obs_tgt, e_tgt);
    else if (!RESOLVE) check("branch_target_off", obs_tgt, 32'h0);
    check("dbg_read", obs_dbg, e_dbg);
    check("halted_pre", bus.o_halted, m_halted);

    @(posedge clk);
    #1;
    all_fields = 1'b0;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_halted = 0;  m_stalled = 0;
      e_valid = 0;  e_ctrl = 0;  e_a = 0;  e_b = 0;  e_imm = 0;  e_pc = 0;  e_rs = 0;  e_rt = 0;  e_rd = 0;
      all_fields = 1'b1;
    end else if (bus.i_enable) begin
      if (bus.i_wb_reg_write && bus.i_wb_write_reg != 0) m_regs[bus.i_wb_write_reg] = bus.i_wb_write_data;
      e_valid = iss;  e_ctrl = iss ? ctl : 7'h0;
      e_a = ra;  e_b = rb;  e_imm = sext;  e_pc = bus.i_pc;  e_rs = rs;  e_rt = rt;  e_rd = rd;
      if (m_halted)                          m_halted = 1;
      else if (m_stalled)                    m_stalled = 0;
      else if (hz)                           m_stalled = 1;
      else if (bus.i_valid && op == 6'h3f)   m_halted = 1;
    end
    check("ex_valid", bus.o_ex_valid, e_valid);
    check("ex_ctrl", bus.o_ex_ctrl, e_ctrl);
    check("halted", bus.o_halted, m_halted);
    if (e_valid || all_fields) begin
      check("ex_data_a", bus.o_ex_data_a, e_a);
      check("ex_data_b", bus.o_ex_data_b, e_b);
      check("ex_imm", bus.o_ex_imm, e_imm);
      check("ex_pc", bus.o_ex_pc, e_pc);
      check("ex_rs", bus.o_ex_rs, e_rs);
      check("ex_rt", bus.o_ex_rt, e_rt);
      check("ex_rd", bus.o_ex_rd, e_rd);
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    n_checks = 0;  n_pass = 0;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h0c};
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_halted = 0;  m_stalled = 0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, debug port reads zero at any address
    rst = 1'b1;  bus.i_dbg_read_addr = 5'($urandom);
    step();
    idle();  bus.i_dbg_read_addr = 5'($urandom_range(1, 31));
    step();
    check("rst_dbg", bus.o_dbg_read_data, 32'h0);
    check("rst_ex_valid", bus.o_ex_valid, 1'b0);
    check("rst_halted", bus.o_halted, 1'b0);

    // Write-first bypass into operand A; r0 write ignored
    idle();  wb(5'd5, 32'h0000_00AA);  bus.i_valid = 1;  bus.i_inst = mk_r(5'd5, 5'd0, 5'd6);  bus.i_pc = 32'h4;
    step();
    check("bypass_a", bus.o_ex_data_a, 32'h0000_00AA);
    idle();  wb(5'd0, 32'h1234);  bus.i_dbg_read_addr = 5'd0;
    step();
    check("r0_zero", obs_dbg, 32'h0);

    // Load-use: LW rt=3 in EX, ADD rs=3 in ID
    idle();  wb(5'd3, 32'h33);
    step();
    idle();  bus.i_ex_mem_read = 1;  bus.i_ex_rt = 5'd3;  bus.i_valid = 1;  bus.i_inst = mk_r(5'd3, 5'd7, 5'd8);
    step();
    check("lu_stall", obs_stall, 1'b1);
    check("lu_bubble", bus.o_ex_valid, 1'b0);
    bus.i_ex_mem_read = 0;
    step();
    check("lu_stall_once", obs_stall, 1'b0);
    check("lu_issue", bus.o_ex_valid, 1'b1);
    check("lu_ctrl", bus.o_ex_ctrl, 7'b1000110);
    check("lu_data", bus.o_ex_data_a, 32'h33);

    // Branch resolution at pc 0x10, imm -2
    idle();  wb(5'd1, 32'd7);  step();
    idle();  wb(5'd2, 32'd7);  step();
    idle();  bus.i_valid = 1;  bus.i_pc = 32'h10;  bus.i_inst = mk_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
    step();
    check("beq_flush", obs_flush, RESOLVE);
    check("beq_target", RESOLVE ? obs_tgt : 32'h0E, 32'h0E);
    check("beq_ctrl", bus.o_ex_ctrl, RESOLVE ? 7'b0 : 7'b0000001);
    bus.i_inst = mk_i(6'h05, 5'd1, 5'd2, 16'hFFFE);
    step();
    check("bne_flush", obs_flush, 1'b0);

    // Freeze: writeback ignored, pipeline register held
    idle();  wb(5'd4, 32'h55);  step();
    idle();  bus.i_valid = 1;  bus.i_inst = mk_r(5'd4, 5'd1, 5'd9);  step();
    idle();  bus.i_enable = 0;  wb(5'd4, 32'd9);  bus.i_valid = 1;  bus.i_inst = mk_r(5'd2, 5'd2, 5'd2);
    step();
    step();
    check("freeze_stall", obs_stall, 1'b0);
    check("freeze_a", bus.o_ex_data_a, 32'h55);
    check("freeze_rd", bus.o_ex_rd, 5'd9);
    idle();  bus.i_dbg_read_addr = 5'd4;
    step();
    check("freeze_r4", obs_dbg, 32'h55);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.i_enable = ($urandom_range(0, 9) != 0);
      bus.i_valid  = ($urandom_range(0, 4) != 0);
      bus.i_inst   = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      bus.i_pc     = $urandom;
      bus.i_wb_reg_write  = $urandom_range(0, 1);
      bus.i_wb_write_reg  = 5'($urandom_range(0, 7));
      bus.i_wb_write_data = $urandom;
      bus.i_ex_mem_read   = ($urandom_range(0, 4) < 2);
      bus.i_ex_rt         = 5'($urandom_range(0, 7));
      bus.i_dbg_read_addr = 5'($urandom_range(0, 7));
      step();
    end

    // HALT: sticky until reset
    idle();  step();
    idle();  bus.i_valid = 1;  bus.i_inst = {6'h3f, 26'h0};
    step();
    check("halt_set", bus.o_halted, 1'b1);
    check("halt_bubble", bus.o_ex_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.i_inst = mk_r(5'd1, 5'd2, 5'd3);
      step();
      check("halt_stall", obs_stall, 1'b1);
      check("halt_valid", bus.o_ex_valid, 1'b0);
    end
    rst = 1'b1;  step();
    rst = 1'b0;  step();
    check("halt_cleared", bus.o_halted, 1'b0);
    check("post_halt_issue", bus.o_ex_valid, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
